// File: rtl/tt_um_logic_arbiter.sv
// Round-robin shared 8-bit logic unit with accumulator.
// Four requesters each apply a fixed bitwise op to acc.
module tt_um_logic_arbiter (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EXEC,
        HOLD
    } state_t;

    state_t     state;
    logic [7:0] acc;
    logic [7:0] opnd_r;
    logic [1:0] rr_ptr;
    logic [1:0] sel;
    logic [3:0] grant;

    logic [3:0] req;
    logic [7:0] opnd_b;
    logic [1:0] win;
    logic [1:0] idx;
    logic [7:0] result;
    logic       unused_ok;

    assign req       = ui_in[3:0];
    assign opnd_b    = {ui_in[7:4], uio_in[3:0]};
    assign unused_ok = &{1'b0, uio_in[7:4]};

    // Pick the first active request starting at rr_ptr; the lowest
    // offset from rr_ptr is written last so it wins.
    always_comb begin
        win = rr_ptr;
        idx = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    // Fixed operation of the granted requester.
    always_comb begin
        result = acc;
        unique case (sel)
            2'd0: result = acc & opnd_r;
            2'd1: result = acc & ~opnd_r;
            2'd2: result = acc | opnd_r;
            2'd3: result = acc ^ opnd_r;
        endcase
    end

    // Sequencer: arbitrate, capture operand, execute, hold until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= 8'h00;
            opnd_r <= 8'h00;
            rr_ptr <= 2'd0;
            sel    <= 2'd0;
            grant  <= 4'b0000;
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        sel   <= win;
                        grant <= 4'b0001 << win;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    opnd_r <= opnd_b;
                    state  <= EXEC;
                end
                EXEC: begin
                    acc    <= result;
                    rr_ptr <= sel + 2'd1;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (!req[sel]) begin
                        grant <= 4'b0000;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign uo_out  = acc;
    assign uio_out = {grant, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_logic_arbiter.sv
// Bench for tt_um_logic_arbiter: randomized transactions
// checked against a transaction-level reference model.
module tb_tt_um_logic_arbiter;

    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       ena    = 1'b1;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    logic [7:0] acc_m;
    logic [1:0] ptr_m;

    tt_um_logic_arbiter dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    // Reference: first requester found walking ptr, ptr+1, ... mod 4.
    function automatic int pick(input int ptr, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] apply(input int who,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (who)
            0: return a & b;
            1: return a & ~b;
            2: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [7:0] gnt_pins(input int who);
        logic [7:0] v;
        v = 8'h00;
        if (who >= 0) v[4 + who] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        ui_in[3:0] = r;
    endtask

    task automatic set_b(input logic [7:0] b);
        ui_in[7:4] = b[7:4];
        uio_in     = {4'($urandom), b[3:0]};
    endtask

    task automatic do_reset;
        set_req(4'h0);
        ena   = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        acc_m = 8'h00;
        ptr_m = 2'd0;
        tick();
    endtask

    task automatic test_reset;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        rst_n  = 1'b0;
        #1;
        tick();
        tick();
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
            errors++;
            $display("FAIL reset_vals: got %h/%h/%h want 00/00/f0",
                     uo_out, uio_out, uio_oe);
        end
        set_req(4'h0);
        ena   = 1'b1;
        rst_n = 1'b1;
        acc_m = 8'h00;
        ptr_m = 2'd0;
        for (int i = 0; i < 10; i++) begin
            set_b(8'($urandom));
            tick();
            checks++;
            if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
                errors++;
                $display("FAIL reset_idle: cyc %0d got %h/%h/%h want 00/00/f0",
                         i, uo_out, uio_out, uio_oe);
            end
        end
    endtask

    task automatic test_single_or;
        int w;
        logic [7:0] exp;
        w = pick(ptr_m, 4'b0100);
        set_req(4'b0100);
        tick();
        checks++;
        if (uio_out !== gnt_pins(w)) begin
            errors++;
            $display("FAIL or_grant: got %h want %h", uio_out, gnt_pins(w));
        end
        set_b(8'h5A);
        tick();
        set_b(8'($urandom));
        tick();
        exp = apply(w, acc_m, 8'h5A);
        checks++;
        if (uo_out !== exp) begin
            errors++;
            $display("FAIL or_acc: got %h want %h", uo_out, exp);
        end
        acc_m = exp;
        ptr_m = 2'(w + 1);
        set_req(4'h0);
        tick();
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL or_release: got %h want 00", uio_out);
        end
    endtask

    task automatic test_chain;
        int who_t [3];
        logic [7:0] b_t [3];
        logic [7:0] exp;
        int w;
        who_t = '{3, 1, 0};
        b_t   = '{8'hFF, 8'h0F, 8'h00};
        for (int i = 0; i < 3; i++) begin
            w = pick(ptr_m, 4'(1 << who_t[i]));
            set_req(4'(1 << who_t[i]));
            tick();
            set_b(b_t[i]);
            tick();
            tick();
            exp = apply(w, acc_m, b_t[i]);
            checks++;
            if (uo_out !== exp || uio_out !== gnt_pins(w)) begin
                errors++;
                $display("FAIL chain%0d: got acc %h gnt %h want %h %h",
                         i, uo_out, uio_out, exp, gnt_pins(w));
            end
            acc_m = exp;
            ptr_m = 2'(w + 1);
            set_req(4'h0);
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] r;
        logic [7:0] b;
        logic [7:0] exp;
        int w;
        int order [6];
        logic [3:0] req_t [6];
        do_reset();
        req_t = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h2, 4'h5};
        for (int i = 0; i < 6; i++) begin
            r = req_t[i];
            if (i == 5) r = 4'h5;
            w = pick(ptr_m, r);
            order[i] = w;
            set_req(r);
            tick();
            checks++;
            if (uio_out !== gnt_pins(w)) begin
                errors++;
                $display("FAIL rr_grant%0d: got %h want %h",
                         i, uio_out, gnt_pins(w));
            end
            b = 8'($urandom);
            set_b(b);
            tick();
            tick();
            exp = apply(w, acc_m, b);
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("FAIL rr_acc%0d: got %h want %h", i, uo_out, exp);
            end
            acc_m = exp;
            ptr_m = 2'(w + 1);
            r[w] = 1'b0;
            set_req(r);
            tick();
            checks++;
            if (uio_out !== 8'h00) begin
                errors++;
                $display("FAIL rr_gap%0d: got %h want 00", i, uio_out);
            end
            if (i == 4) set_req(4'h0);
        end
        set_req(4'h0);
        tick();
    endtask

    task automatic test_ena_freeze;
        logic [7:0] b;
        logic [7:0] exp;
        int w;
        w = pick(ptr_m, 4'b1000);
        set_req(4'b1000);
        tick();
        b = 8'($urandom);
        set_b(b);
        tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_b(~b);
            tick();
            checks++;
            if (uo_out !== acc_m || uio_out !== gnt_pins(w)) begin
                errors++;
                $display("FAIL ena_hold%0d: got %h %h want %h %h",
                         i, uo_out, uio_out, acc_m, gnt_pins(w));
            end
        end
        ena = 1'b1;
        tick();
        exp = apply(w, acc_m, b);
        checks++;
        if (uo_out !== exp) begin
            errors++;
            $display("FAIL ena_resume: got %h want %h", uo_out, exp);
        end
        acc_m = exp;
        ptr_m = 2'(w + 1);
        set_req(4'h0);
        tick();
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic [7:0] b;
        logic [7:0] exp;
        int w;
        int extra;
        bit early;
        for (int n = 0; n < 40; n++) begin
            r = 4'($urandom_range(1, 15));
            w = pick(ptr_m, r);
            set_req(r);
            tick();
            checks++;
            if (uio_out !== gnt_pins(w)) begin
                errors++;
                $display("FAIL rand_grant%0d: got %h want %h",
                         n, uio_out, gnt_pins(w));
            end
            b = 8'($urandom);
            set_b(b);
            tick();
            early = 1'($urandom);
            r = 4'($urandom);
            if (early) r[w] = 1'b0;
            else r[w] = 1'b1;
            set_req(r);
            set_b(8'($urandom));
            tick();
            exp = apply(w, acc_m, b);
            checks++;
            if (uo_out !== exp || uio_out !== gnt_pins(w)) begin
                errors++;
                $display("FAIL rand_acc%0d: got %h %h want %h %h",
                         n, uo_out, uio_out, exp, gnt_pins(w));
            end
            acc_m = exp;
            ptr_m = 2'(w + 1);
            extra = early ? 0 : $urandom_range(0, 2);
            for (int k = 0; k < extra; k++) begin
                tick();
                checks++;
                if (uio_out !== gnt_pins(w)) begin
                    errors++;
                    $display("FAIL rand_hold%0d: got %h want %h",
                             n, uio_out, gnt_pins(w));
                end
            end
            r[w] = 1'b0;
            set_req(r);
            tick();
            checks++;
            if (uio_out !== 8'h00) begin
                errors++;
                $display("FAIL rand_gap%0d: got %h want 00", n, uio_out);
            end
        end
        set_req(4'h0);
        tick();
    endtask

    task automatic test_reset_mid_op;
        int w;
        logic [7:0] exp;
        do_reset();
        w = pick(ptr_m, 4'b0100);
        set_req(4'b0100);
        tick();
        set_b(8'h3C);
        tick();
        tick();
        exp = apply(w, acc_m, 8'h3C);
        checks++;
        if (uo_out !== exp || uio_out !== gnt_pins(w)) begin
            errors++;
            $display("FAIL mid_setup: got %h %h want %h %h",
                     uo_out, uio_out, exp, gnt_pins(w));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
            errors++;
            $display("FAIL mid_async: got %h/%h/%h want 00/00/f0",
                     uo_out, uio_out, uio_oe);
        end
        #1;
        rst_n = 1'b1;
        acc_m = 8'h00;
        ptr_m = 2'd0;
        set_req(4'hF);
        w = pick(ptr_m, 4'hF);
        tick();
        checks++;
        if (uio_out !== gnt_pins(w) || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_ptr: got %h %h want %h 00",
                     uio_out, uo_out, gnt_pins(w));
        end
        set_req(4'h0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_or();
        test_chain();
        test_round_robin();
        test_ena_freeze();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_logic_arbiter.md
# tt_um_logic_arbiter

Tiny Tapeout user module that shares one 8-bit bitwise logic unit and its accumulator between four requesters. A round-robin arbiter grants one requester at a time. A small sequencer then:
- captures an 8-bit operand,
- applies the requester's fixed operation to the accumulator,
- holds the grant until the requester releases.

The accumulator drives the dedicated outputs; grants are returned on the upper bidirectional pins.

## Interface
Parameters: none.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ena  in  1  enable; when low, all state holds
- ui_in  in  8  [3:0] = req[3:0], level-sensitive requests; [7:4] = operand B[7:4]
- uio_in  in  8  [3:0] = operand B[3:0]; [7:4] ignored
- uo_out  out  8  accumulator acc[7:0]
- uio_out  out  8  [7:4] = grant[3:0], one-hot or zero; [3:0] = 0
- uio_oe  out  8  constant 8'hF0

## Operation
- Fixed operation per requester, B = {ui_in[7:4], uio_in[3:0]} captured into opnd_r:
  - req0: acc & B
  - req1: acc & ~B
  - req2: acc | B
  - req3: acc ^ B
- State register rr_ptr[1:0] is the highest-priority index. Priority order is rr_ptr, rr_ptr+1, … mod 4.
- FSM states: IDLE, GRANT, EXEC, HOLD.
  - IDLE: if req != 0, latch the winner index into sel, set grant = onehot(sel), go to GRANT. Otherwise stay.
  - GRANT: opnd_r <= B; go to EXEC.
  - EXEC: acc <= f_sel(acc, opnd_r); rr_ptr <= sel+1 (2-bit wrap, 3 -> 0); go to HOLD.
  - HOLD: while req[sel] = 1, stay with grant held. When req[sel] = 0, grant <= 0; go to IDLE.
- A granted operation always completes. Dropping req[sel] during GRANT or EXEC does not abort the operation; it only shortens HOLD to one cycle.
- Requests from other requesters during GRANT, EXEC or HOLD are not latched. They compete at the next IDLE evaluation.
- Widths: all arithmetic is 8-bit bitwise; no carries. rr_ptr wraps modulo 4.
- ena = 0: the FSM, acc, opnd_r, rr_ptr and grant all hold their values. Outputs keep driving the held values.
- Reset (rst_n = 0, any state, including mid-operation), applied asynchronously:
  - state = IDLE, acc = 8'h00, opnd_r = 8'h00, rr_ptr = 0, sel = 0, grant = 4'b0000
  - uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hF0
  - The in-flight operation is discarded.

## Timing
- Edge e0 (state IDLE, req sampled nonzero): grant is visible after e0.
- Edge e1: B is sampled at e1. Operand pins must be stable in the cycle after grant rises.
- Edge e2: the new acc is visible on uo_out after e2, two cycles after grant rises.
- HOLD lasts at least one cycle. grant falls on the first edge at which req[sel] is sampled low in HOLD.
- Back-to-back throughput is at most one operation per 4 cycles: GRANT, EXEC, one HOLD cycle, one IDLE cycle.
  - IDLE always lasts at least one cycle.
  - grant never goes directly from one one-hot value to another; there is at least one zero cycle between grants.
- All outputs are registered or constant; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert rst_n = 0 with random inputs -> uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hF0. Release reset with req = 0 -> outputs unchanged for 10 cycles.
- **Single OR:** hold req2, with B = 8'h5A applied in the cycle after grant -> uio_out = 8'h40 one edge after req is sampled, and uo_out = 8'h5A two edges later. Drop req2 -> uio_out = 8'h00 at the next edge.
- **Operation chain from acc = 8'h5A:**
  - req3 with B = 8'hFF -> 8'hA5
  - req1 with B = 8'h0F -> 8'hA0
  - req0 with B = 8'h00 -> 8'h00
- **Round-robin:** from reset, raise req[3:0] = 4'hF and drop each request once it is granted -> grants appear in order 0, 1, 2, 3, separated by zero cycles. Then with rr_ptr = 0, raise req0 and req2 after serving req1 (so rr_ptr = 2) -> req2 is granted before req0.
- **ena freeze:** drive ena = 0 for 5 cycles during EXEC -> acc and grant are unchanged. After ena returns, the operation completes with the original opnd_r.
- **Reset mid-operation:** pulse rst_n low in HOLD with grant = 4'b0100 and acc = 8'h3C -> grant and acc are 0 immediately, without waiting for a clock edge, and rr_ptr = 0 afterwards.
